// File: rtl/window_watchdog_ctrl.sv
// ---------------------------------------------------------------------------
// window_watchdog_ctrl
//
// Window-watchdog sequencer. After INIT it times a closed first window
// (FWLEN ticks) followed by an open second window (SWLEN ticks). A service
// event (rising edge of WDSRVC) in the open window restarts the sequence.
// A service in the closed window is an early fault. No service before the
// open window ends is a timeout fault. Each fault pulses SYS_RST for
// RST_PULSE clocks. Once the fault count reaches a non-zero RST_LMT, the
// block locks into SAFE until RST.
//
// Parameters:
//   TICK_DIV  - clocks per window tick (>= 1)
//   RST_PULSE - SYS_RST pulse length in clocks (>= 1)
//
// Ports:
//   CLK      in   system clock
//   RST      in   synchronous reset, active-high
//   INIT     in   watchdog enable (level)
//   WDSRVC   in   service bit (level); a rising edge is one service event
//   FWLEN    in   [7:0] closed-window length in ticks
//   SWLEN    in   [7:0] open-window length in ticks
//   RST_LMT  in   [7:0] fault count that forces SAFE; 0 disables SAFE
//   SYS_RST  out  system reset request
//   WDFAIL   out  sticky safe-state flag
//   WD_STATE out  [2:0] current state encoding
//   FAULT    out  [1:0] last fault: 00 none, 01 early, 10 timeout
//   ERR_CNT  out  [7:0] faults since RST, saturating at 255
// ---------------------------------------------------------------------------
module window_watchdog_ctrl #(
  parameter int unsigned TICK_DIV  = 1000,
  parameter int unsigned RST_PULSE = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       INIT,
  input  logic       WDSRVC,
  input  logic [7:0] FWLEN,
  input  logic [7:0] SWLEN,
  input  logic [7:0] RST_LMT,
  output logic       SYS_RST,
  output logic       WDFAIL,
  output logic [2:0] WD_STATE,
  output logic [1:0] FAULT,
  output logic [7:0] ERR_CNT
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CW = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] PULSE_MAX = CW'(RST_PULSE - 1);

  typedef enum logic [2:0] {
    ST_DISABLED = 3'b000,
    ST_FIRST    = 3'b001,
    ST_SECOND   = 3'b010,
    ST_RESET    = 3'b011,
    ST_SAFE     = 3'b100
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [7:0]      wincnt_q, wincnt_d;
  logic [CW-1:0]   pulse_q, pulse_d;
  logic            wdsrvc_q;
  logic [1:0]      fault_q, fault_d;
  logic [7:0]      err_cnt_q, err_cnt_d;
  logic            sys_rst_q, sys_rst_d;
  logic            wdfail_q, wdfail_d;

  logic            srv_s;
  logic            tick_s;
  logic [8:0]      win_next_s;
  logic [8:0]      err_inc_s;
  logic            fw_done_s;
  logic            sw_done_s;
  logic            lock_s;
  logic            enter_win_s;
  logic            fault_det_s;
  logic [1:0]      fault_code_s;

  assign srv_s      = WDSRVC & ~wdsrvc_q;
  assign tick_s     = (presc_q == PRESC_MAX);
  assign win_next_s = {1'b0, wincnt_q} + 9'd1;
  assign err_inc_s  = {1'b0, err_cnt_q} + 9'd1;

  // A zero length ends the window after one clock regardless of ticks.
  // The >= compare also ends the window if the length is lowered below
  // the running count mid-window, so the counter can never wrap.
  assign fw_done_s = (FWLEN == 8'd0) | (tick_s & (win_next_s >= {1'b0, FWLEN}));
  assign sw_done_s = (SWLEN == 8'd0) | (tick_s & (win_next_s >= {1'b0, SWLEN}));

  // The lock decision uses the unsaturated count so it is exact at 255.
  assign lock_s = (RST_LMT != 8'd0) && (err_inc_s >= {1'b0, RST_LMT});

  // Next-state logic and fault detection
  always_comb begin
    state_d      = state_q;
    fault_det_s  = 1'b0;
    fault_code_s = 2'b00;
    case (state_q)
      ST_DISABLED: begin
        if (INIT) begin
          state_d = ST_FIRST;
        end else begin
          state_d = ST_DISABLED;
        end
      end
      ST_FIRST: begin
        if (srv_s) begin
          fault_det_s  = 1'b1;
          fault_code_s = 2'b01;
          state_d      = lock_s ? ST_SAFE : ST_RESET;
        end else if (!INIT) begin
          state_d = ST_DISABLED;
        end else if (fw_done_s) begin
          state_d = ST_SECOND;
        end else begin
          state_d = ST_FIRST;
        end
      end
      ST_SECOND: begin
        // A service beats a coincident timeout.
        if (srv_s) begin
          state_d = ST_FIRST;
        end else if (sw_done_s) begin
          fault_det_s  = 1'b1;
          fault_code_s = 2'b10;
          state_d      = lock_s ? ST_SAFE : ST_RESET;
        end else if (!INIT) begin
          state_d = ST_DISABLED;
        end else begin
          state_d = ST_SECOND;
        end
      end
      ST_RESET: begin
        if (pulse_q == PULSE_MAX) begin
          state_d = INIT ? ST_FIRST : ST_DISABLED;
        end else begin
          state_d = ST_RESET;
        end
      end
      ST_SAFE: begin
        state_d = ST_SAFE;
      end
      default: begin
        state_d = ST_DISABLED;
      end
    endcase
  end

  // Counter, fault-record and registered-output next values
  always_comb begin
    presc_d     = presc_q;
    wincnt_d    = wincnt_q;
    pulse_d     = pulse_q;
    fault_d     = fault_q;
    err_cnt_d   = err_cnt_q;
    enter_win_s = (state_d != state_q) &&
                  ((state_d == ST_FIRST) || (state_d == ST_SECOND));

    if (enter_win_s) begin
      presc_d  = {PW{1'b0}};
      wincnt_d = 8'd0;
    end else if ((state_q == ST_FIRST) || (state_q == ST_SECOND)) begin
      if (tick_s) begin
        presc_d  = {PW{1'b0}};
        wincnt_d = win_next_s[7:0];
      end else begin
        presc_d  = presc_q + PW'(1'b1);
        wincnt_d = wincnt_q;
      end
    end else begin
      presc_d  = {PW{1'b0}};
      wincnt_d = 8'd0;
    end

    // Pulse counter runs only while staying in RESET; it restarts at 0
    // on each entry so the pulse is always RST_PULSE clocks long.
    if ((state_q == ST_RESET) && (state_d == ST_RESET)) begin
      pulse_d = pulse_q + CW'(1'b1);
    end else begin
      pulse_d = {CW{1'b0}};
    end

    if (fault_det_s) begin
      fault_d   = fault_code_s;
      err_cnt_d = (err_cnt_q == 8'd255) ? 8'd255 : err_inc_s[7:0];
    end else begin
      fault_d   = fault_q;
      err_cnt_d = err_cnt_q;
    end

    sys_rst_d = (state_d == ST_RESET) || (state_d == ST_SAFE);
    wdfail_d  = (state_d == ST_SAFE);
  end

  // State, counters and output registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_DISABLED;
      presc_q   <= {PW{1'b0}};
      wincnt_q  <= 8'd0;
      pulse_q   <= {CW{1'b0}};
      wdsrvc_q  <= 1'b0;
      fault_q   <= 2'b00;
      err_cnt_q <= 8'd0;
      sys_rst_q <= 1'b0;
      wdfail_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      wincnt_q  <= wincnt_d;
      pulse_q   <= pulse_d;
      wdsrvc_q  <= WDSRVC;
      fault_q   <= fault_d;
      err_cnt_q <= err_cnt_d;
      sys_rst_q <= sys_rst_d;
      wdfail_q  <= wdfail_d;
    end
  end

  assign SYS_RST  = sys_rst_q;
  assign WDFAIL   = wdfail_q;
  assign WD_STATE = state_q;
  assign FAULT    = fault_q;
  assign ERR_CNT  = err_cnt_q;

endmodule

// File: tb/tb_window_watchdog_ctrl.sv
// ---------------------------------------------------------------------------
// tb_window_watchdog_ctrl
//
// Directed bench for window_watchdog_ctrl with TICK_DIV=1, RST_PULSE=4.
// Inputs are driven and outputs sampled 1 ns after each rising edge.
// Expected values are hand-derived clock counts and state codes.
// ---------------------------------------------------------------------------
module tb_window_watchdog_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       INIT;
  logic       WDSRVC;
  logic [7:0] FWLEN;
  logic [7:0] SWLEN;
  logic [7:0] RST_LMT;
  logic       SYS_RST;
  logic       WDFAIL;
  logic [2:0] WD_STATE;
  logic [1:0] FAULT;
  logic [7:0] ERR_CNT;

  int n_checks = 0;
  int n_errors = 0;

  window_watchdog_ctrl #(
    .TICK_DIV (1),
    .RST_PULSE(4)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .INIT    (INIT),
    .WDSRVC  (WDSRVC),
    .FWLEN   (FWLEN),
    .SWLEN   (SWLEN),
    .RST_LMT (RST_LMT),
    .SYS_RST (SYS_RST),
    .WDFAIL  (WDFAIL),
    .WD_STATE(WD_STATE),
    .FAULT   (FAULT),
    .ERR_CNT (ERR_CNT)
  );

  // 100 MHz clock
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic sys, input logic fail,
                            input logic [2:0] st, input logic [1:0] flt, input logic [7:0] err);
    check_val({tag, ".sys_rst"}, {31'd0, SYS_RST}, {31'd0, sys});
    check_val({tag, ".wdfail"},  {31'd0, WDFAIL},  {31'd0, fail});
    check_val({tag, ".state"},   {29'd0, WD_STATE}, {29'd0, st});
    check_val({tag, ".fault"},   {30'd0, FAULT},   {30'd0, flt});
    check_val({tag, ".err_cnt"}, {24'd0, ERR_CNT}, {24'd0, err});
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic do_reset();
    RST    = 1'b1;
    INIT   = 1'b0;
    WDSRVC = 1'b0;
    step(2);
    RST = 1'b0;
  endtask

  // Enables the watchdog; returns just after the FIRST entry edge.
  task automatic start_first();
    INIT = 1'b1;
    step(1);
  endtask

  // Hard time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    RST     = 1'b1;
    INIT    = 1'b0;
    WDSRVC  = 1'b0;
    FWLEN   = 8'd3;
    SWLEN   = 8'd4;
    RST_LMT = 8'd0;

    // ---------------- reset and good service ----------------
    do_reset();
    check_outs("reset", 1'b0, 1'b0, 3'b000, 2'b00, 8'd0);
    start_first();
    check_val("good.first_e0", {29'd0, WD_STATE}, 32'd1);
    step(1);
    check_val("good.first_e1", {29'd0, WD_STATE}, 32'd1);
    step(1);
    check_val("good.first_e2", {29'd0, WD_STATE}, 32'd1);
    step(1);
    check_val("good.second_e3", {29'd0, WD_STATE}, 32'd2);
    step(1);
    check_val("good.second_e4", {29'd0, WD_STATE}, 32'd2);
    WDSRVC = 1'b1;               // rising edge during 2nd clock of SECOND
    step(1);
    check_outs("good.refirst", 1'b0, 1'b0, 3'b001, 2'b00, 8'd0);
    WDSRVC = 1'b0;

    // ---------------- early service ----------------
    do_reset();
    RST_LMT = 8'd0;
    start_first();
    WDSRVC = 1'b1;               // edge on 1st clock of FIRST
    step(1);
    WDSRVC = 1'b0;
    check_outs("early.fault", 1'b1, 1'b0, 3'b011, 2'b01, 8'd1);
    for (int i = 0; i < 3; i++) begin
      step(1);
      check_val("early.pulse", {31'd0, SYS_RST}, 32'd1);
    end
    step(1);
    check_outs("early.after", 1'b0, 1'b0, 3'b001, 2'b01, 8'd1);

    // ---------------- timeout ----------------
    do_reset();
    FWLEN = 8'd3;
    SWLEN = 8'd4;
    start_first();
    for (int i = 1; i <= 6; i++) begin
      step(1);
      check_val("timeout.window", {29'd0, WD_STATE}, (i < 3) ? 32'd1 : 32'd2);
    end
    step(1);                     // 7th clock after FIRST entry
    check_outs("timeout.fault", 1'b1, 1'b0, 3'b011, 2'b10, 8'd1);
    step(3);
    check_val("timeout.pulse4", {31'd0, SYS_RST}, 32'd1);
    step(1);
    check_outs("timeout.after", 1'b0, 1'b0, 3'b001, 2'b10, 8'd1);

    // ---------------- safe lock ----------------
    do_reset();
    RST_LMT = 8'd2;
    start_first();
    step(7);
    check_outs("safe.fault1", 1'b1, 1'b0, 3'b011, 2'b10, 8'd1);
    step(4);
    check_val("safe.refirst", {29'd0, WD_STATE}, 32'd1);
    step(7);
    check_outs("safe.locked", 1'b1, 1'b1, 3'b100, 2'b10, 8'd2);
    INIT = 1'b0;
    for (int i = 0; i < 6; i++) begin
      WDSRVC = ~WDSRVC;
      step(1);
    end
    check_outs("safe.hold", 1'b1, 1'b1, 3'b100, 2'b10, 8'd2);
    RST = 1'b1;
    step(1);
    check_outs("safe.rst", 1'b0, 1'b0, 3'b000, 2'b00, 8'd0);
    RST     = 1'b0;
    RST_LMT = 8'd0;

    // ---------------- FWLEN = 0 ----------------
    do_reset();
    FWLEN = 8'd0;
    SWLEN = 8'd4;
    start_first();
    step(1);
    check_val("fw0.second", {29'd0, WD_STATE}, 32'd2);

    // ---------------- SWLEN = 0 with service, then without ----------------
    do_reset();
    FWLEN = 8'd0;
    SWLEN = 8'd0;
    start_first();
    step(1);
    check_val("sw0.second", {29'd0, WD_STATE}, 32'd2);
    WDSRVC = 1'b1;               // edge on first SECOND clock
    step(1);
    check_outs("sw0.srv_wins", 1'b0, 1'b0, 3'b001, 2'b00, 8'd0);
    WDSRVC = 1'b0;
    step(1);
    check_val("sw0.second2", {29'd0, WD_STATE}, 32'd2);
    step(1);
    check_outs("sw0.timeout", 1'b1, 1'b0, 3'b011, 2'b10, 8'd1);

    // ---------------- RST during 2nd pulse clock ----------------
    step(1);
    check_val("midrst.pulse2", {31'd0, SYS_RST}, 32'd1);
    RST = 1'b1;
    step(1);
    check_outs("midrst.cleared", 1'b0, 1'b0, 3'b000, 2'b00, 8'd0);
    RST = 1'b0;

    // ---------------- ERR_CNT saturation ----------------
    // FWLEN=SWLEN=0: one fault every 6 clocks, 1900 clocks > 300 faults.
    do_reset();
    FWLEN   = 8'd0;
    SWLEN   = 8'd0;
    RST_LMT = 8'd0;
    start_first();
    step(1900);
    check_val("sat.err_cnt", {24'd0, ERR_CNT}, 32'd255);
    check_val("sat.fault", {30'd0, FAULT}, 32'd2);
    check_val("sat.no_safe", {31'd0, WDFAIL}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/window_watchdog_ctrl.md
Name: window_watchdog_ctrl

Overview:
- Window-watchdog sequencer driven by the configuration register outputs: FWLEN, SWLEN, RST_LMT, INIT and WDSRVC.
- Times a closed first window and an open second window.
- Classifies service events as good, early or missing.
- Pulses a system reset on a fault, and locks into a safe state once the fault count reaches RST_LMT.

Parameters:
- TICK_DIV, 1000: clocks per window tick; must be 1 or more.
- RST_PULSE, 4: SYS_RST pulse length in clocks; must be 1 or more.

Ports:
- CLK  input  1  system clock
- RST  input  1  synchronous reset, active-high
- INIT  input  1  watchdog enable (level)
- WDSRVC  input  1  service bit (level); a rising edge is one service event
- FWLEN  input  8  closed-window length in ticks
- SWLEN  input  8  open-window length in ticks
- RST_LMT  input  8  fault count that forces SAFE; 0 disables SAFE
- SYS_RST  output  1  system reset request
- WDFAIL  output  1  sticky safe-state flag
- WD_STATE  output  3  current state encoding
- FAULT  output  2  last fault: 00 none, 01 early service, 10 timeout
- ERR_CNT  output  8  faults since RST, saturates at 255

Behaviour:
- Reset (RST=1 at a clock edge):
  - State goes to DISABLED.
  - SYS_RST=0, WDFAIL=0, WD_STATE=000, FAULT=00, ERR_CNT=0.
  - Prescaler, window counter and the WDSRVC edge register are cleared.
  - Reset has priority in every state, including mid-pulse and SAFE.
- Service edge:
  - srv = WDSRVC & ~wdsrvc_q, where wdsrvc_q is WDSRVC registered every clock.
  - srv is ignored in DISABLED, RESET and SAFE.
- Tick generation:
  - Prescaler counts 0..TICK_DIV-1; a tick occurs when prescaler = TICK_DIV-1.
  - Prescaler and window counter clear on every entry to FIRST or SECOND.
  - A window of length L ticks therefore lasts exactly L*TICK_DIV clocks.
- States (WD_STATE encoding):
  - DISABLED (000): when INIT=1, go to FIRST next clock.
  - FIRST (001), closed window:
    - srv → fault, code 01.
    - Else, on a tick with wincnt+1 = FWLEN → SECOND.
    - FWLEN=0 → go to SECOND after one clock.
    - INIT=0 with no fault this clock → DISABLED.
  - SECOND (010), open window:
    - srv → FIRST (good service; FAULT and ERR_CNT unchanged).
    - Else, on a tick with wincnt+1 = SWLEN → fault, code 10.
    - SWLEN=0 → fault on the first clock in SECOND unless srv is present.
    - If srv and the timeout coincide, srv wins.
    - INIT=0 → DISABLED.
  - Fault (evaluated in the same clock as detection):
    - FAULT ← code.
    - ERR_CNT ← ERR_CNT+1, saturating at 255.
    - If RST_LMT≠0 and ERR_CNT+1 ≥ RST_LMT → SAFE; else → RESET.
  - RESET (011):
    - SYS_RST=1 for exactly RST_PULSE clocks, starting the clock after detection.
    - Then go to FIRST if INIT=1, else DISABLED.
    - INIT changes during the pulse do not shorten it.
  - SAFE (100):
    - SYS_RST=1 and WDFAIL=1 continuously.
    - Only RST exits; INIT and WDSRVC are ignored.
- Outputs:
  - All outputs are registered.
  - WD_STATE reflects the state register.
  - SYS_RST is 1 only in RESET and SAFE.
- Configuration inputs:
  - FWLEN, SWLEN and RST_LMT are sampled live at each comparison.
  - A change mid-window takes effect at the next tick compare.
- Window counter is 8 bits and never wraps: the compare terminates the window before overflow.

Test Plan:
- All scenarios use TICK_DIV=1, RST_PULSE=4.
- Reset and good service:
  - Stimulus: assert RST. Then set INIT=1, FWLEN=3, SWLEN=4, and give a WDSRVC rising edge on the 2nd clock of SECOND.
  - Required: after reset all outputs are 0 and WD_STATE=000. DISABLED→FIRST; FIRST lasts 3 clocks; after the service, FIRST is re-entered. SYS_RST stays 0, ERR_CNT=0, FAULT=00.
- Early service:
  - Stimulus: WDSRVC edge on the 1st clock of FIRST, RST_LMT=0.
  - Required: FAULT=01 and ERR_CNT=1. SYS_RST is high exactly 4 clocks starting the next clock, then WD_STATE=001.
- Timeout:
  - Stimulus: FWLEN=3, SWLEN=4, no service.
  - Required: the fault occurs on the 7th clock after FIRST entry. FAULT=10, ERR_CNT=1, 4-clock SYS_RST pulse.
- Safe lock:
  - Stimulus: RST_LMT=2, two consecutive timeouts; then INIT=0 and WDSRVC toggles.
  - Required:
    - After the first fault: RESET pulse.
    - After the second fault: WD_STATE=100, WDFAIL=1, SYS_RST held high, ERR_CNT=2.
    - INIT=0 and WDSRVC toggles cause no change.
    - RST clears everything to 0.
- Boundaries:
  - Stimulus: FWLEN=0; separately, SWLEN=0 with a service edge on the first SECOND clock; separately, RST asserted during the 2nd clock of the RESET pulse.
  - Required:
    - FWLEN=0: FIRST lasts 1 clock.
    - SWLEN=0 with simultaneous service: service wins, next state FIRST, no fault.
    - RST mid-pulse: SYS_RST=0 and WD_STATE=000 on the next clock.
